// File: rtl/mlp_pkg.sv
// Shared definitions for the single-MAC MLP layer sequencer.
// Provides the sequencer state encoding, the default accumulator width and
// the address-width helper used to size the RAM address ports.
package mlp_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam int ACC_WIDTH_DEF = 32;

   // Address width for a memory of n entries, never narrower than one bit
   // so single-entry memories still get a real port.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/MLP_mac.sv
// Signed multiply-accumulate unit shared by all neurons of a layer.
// Latency: result is registered one cycle after start/valid.
// No backpressure: start loads a*b, valid adds a*b, otherwise result holds.
// Ports: clk, rst (sync active-high), start, valid, a, b (signed DW), result (signed ACC_WIDTH).
module MLP_mac #(
   parameter int DW        = 8,
   parameter int ACC_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 valid,
   input  logic [DW-1:0]        a,
   input  logic [DW-1:0]        b,
   output logic [ACC_WIDTH-1:0] result
);

   logic signed [2*DW-1:0]  prod;
   logic [ACC_WIDTH-1:0]    prod_ext;
   logic [ACC_WIDTH-1:0]    acc_q;
   logic [ACC_WIDTH-1:0]    acc_d;

   assign prod     = $signed(a) * $signed(b);
   assign prod_ext = {{(ACC_WIDTH - 2*DW){prod[2*DW-1]}}, prod};

   always_comb begin
      acc_d = acc_q;
      if (start) begin
         acc_d = prod_ext;
      end else if (valid) begin
         acc_d = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign result = acc_q;

endmodule

// File: rtl/mlp_addr_gen.sv
// Input/neuron/weight address counters for the layer sequencer.
// Latency: counters update on the clock edge after a control strobe.
// No backpressure of its own: the sequencer only strobes when it may advance.
// Ports: clear_i zeroes all counters, step_i advances to the next input of
// the current neuron, next_i moves to input 0 of the next neuron.
// i_o/w_o/j_o are the counters; last_in_o/last_out_o flag the final input/neuron.
module mlp_addr_gen
   import mlp_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 2,
   parameter int IN_AW  = addr_w(N_IN),
   parameter int W_AW   = addr_w(N_IN * N_OUT),
   parameter int OUT_AW = addr_w(N_OUT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              step_i,
   input  logic              next_i,
   output logic [IN_AW-1:0]  i_o,
   output logic [W_AW-1:0]   w_o,
   output logic [OUT_AW-1:0] j_o,
   output logic              last_in_o,
   output logic              last_out_o
);

   localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
   localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(N_OUT - 1);

   logic [IN_AW-1:0]  i_q, i_d;
   logic [W_AW-1:0]   w_q, w_d;
   logic [OUT_AW-1:0] j_q, j_d;

   // The weight address is a running counter rather than j*N_IN+i. It only
   // advances when a new (i, j) pair is issued, so it stops at
   // N_IN*N_OUT-1 at the end of the layer and never wraps mid-layer.
   always_comb begin
      i_d = i_q;
      w_d = w_q;
      j_d = j_q;
      if (clear_i) begin
         i_d = '0;
         w_d = '0;
         j_d = '0;
      end else if (next_i) begin
         i_d = '0;
         w_d = w_q + 1'b1;
         j_d = j_q + 1'b1;
      end else if (step_i) begin
         i_d = i_q + 1'b1;
         w_d = w_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_q <= '0;
         w_q <= '0;
         j_q <= '0;
      end else begin
         i_q <= i_d;
         w_q <= w_d;
         j_q <= j_d;
      end
   end

   assign i_o        = i_q;
   assign w_o        = w_q;
   assign j_o        = j_q;
   assign last_in_o  = (i_q == I_LAST);
   assign last_out_o = (j_q == J_LAST);

endmodule

// File: rtl/mlp_layer_seq.sv
// Sequencer for one fully-connected layer over a single shared MAC.
// Latency: N_IN+2 cycles from go (or from the previous handshake) to out_valid.
// Backpressure: WRITE holds out_valid/out_idx/out_data and all addresses until out_ready.
// Ports: go/busy/done control; in_addr/w_addr to 1-cycle-latency RAMs;
// mac_start/mac_valid/mac_result to the MAC; out_valid/out_ready/out_idx/out_data downstream.
module mlp_layer_seq
   import mlp_pkg::*;
#(
   parameter int N_IN      = 4,
   parameter int N_OUT     = 2,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int RELU      = 0,
   parameter int IN_AW     = addr_w(N_IN),
   parameter int W_AW      = addr_w(N_IN * N_OUT),
   parameter int OUT_AW    = addr_w(N_OUT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   output logic                 busy,
   output logic                 done,
   output logic [IN_AW-1:0]     in_addr,
   output logic [W_AW-1:0]      w_addr,
   output logic                 mac_start,
   output logic                 mac_valid,
   input  logic [ACC_WIDTH-1:0] mac_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_AW-1:0]    out_idx,
   output logic [ACC_WIDTH-1:0] out_data
);

   state_e state_q, state_d;

   // Issue flags delayed by one cycle so the MAC strobes line up with the
   // RAM read data for the address issued in the previous cycle.
   logic start_q, start_d;
   logic valid_q, valid_d;

   logic              cnt_clear;
   logic              cnt_step;
   logic              cnt_next;
   logic [IN_AW-1:0]  i_cnt;
   logic [W_AW-1:0]   w_cnt;
   logic [OUT_AW-1:0] j_cnt;
   logic              last_in;
   logic              last_out;

   mlp_addr_gen #(
      .N_IN   (N_IN),
      .N_OUT  (N_OUT),
      .IN_AW  (IN_AW),
      .W_AW   (W_AW),
      .OUT_AW (OUT_AW)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (cnt_clear),
      .step_i     (cnt_step),
      .next_i     (cnt_next),
      .i_o        (i_cnt),
      .w_o        (w_cnt),
      .j_o        (j_cnt),
      .last_in_o  (last_in),
      .last_out_o (last_out)
   );

   always_comb begin
      state_d   = state_q;
      cnt_clear = 1'b0;
      cnt_step  = 1'b0;
      cnt_next  = 1'b0;
      case (state_q)
         IDLE: begin
            if (go) begin
               state_d   = ISSUE;
               cnt_clear = 1'b1;
            end
         end
         ISSUE: begin
            // The last input's address is held through DRAIN and WRITE.
            if (last_in) begin
               state_d = DRAIN;
            end else begin
               cnt_step = 1'b1;
            end
         end
         DRAIN: begin
            state_d = WRITE;
         end
         WRITE: begin
            if (out_ready) begin
               if (last_out) begin
                  state_d = DONE;
               end else begin
                  state_d  = ISSUE;
                  cnt_next = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Input 0 of every neuron loads the accumulator, so no stale sum from a
   // previous neuron or an aborted layer can leak into a result.
   always_comb begin
      start_d = (state_q == ISSUE) && (i_cnt == '0);
      valid_d = (state_q == ISSUE) && (i_cnt != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         valid_q <= valid_d;
      end
   end

   assign busy      = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == WRITE);
   assign done      = (state_q == DONE);
   assign in_addr   = i_cnt;
   assign w_addr    = w_cnt;
   assign mac_start = start_q;
   assign mac_valid = valid_q;
   assign out_valid = (state_q == WRITE);

   // The final accumulate lands in the MAC's output register on the edge
   // that enters WRITE, and the MAC receives no strobes while in WRITE, so
   // its registered result (and the neuron counter) are already stable for
   // the whole handshake. Outside WRITE the outputs are forced to zero.
   always_comb begin
      out_idx  = '0;
      out_data = '0;
      if (state_q == WRITE) begin
         out_idx  = j_cnt;
         out_data = mac_result;
         if ((RELU != 0) && mac_result[ACC_WIDTH-1]) begin
            out_data = '0;
         end
      end
   end

endmodule

// File: tb/tb_mlp_layer_seq.sv
module tb_mlp_layer_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc;

   // ---------------- instance A: 4x2, RELU=0 ----------------
   logic        go_a, rdy_a, busy_a, done_a, ms_a, mv_a, ov_a;
   logic [1:0]  ia_a;
   logic [2:0]  wa_a;
   logic [0:0]  oi_a;
   logic [31:0] od_a, mr_a;
   logic [7:0]  id_a, wd_a;

   // ---------------- instance B: 4x2, RELU=1 ----------------
   logic        go_b, rdy_b, busy_b, done_b, ms_b, mv_b, ov_b;
   logic [1:0]  ia_b;
   logic [2:0]  wa_b;
   logic [0:0]  oi_b;
   logic [31:0] od_b, mr_b;
   logic [7:0]  id_b, wd_b;

   // ---------------- instance C: 1x1 ----------------
   logic        go_c, rdy_c, busy_c, done_c, ms_c, mv_c, ov_c;
   logic [0:0]  ia_c;
   logic [0:0]  wa_c;
   logic [0:0]  oi_c;
   logic [31:0] od_c, mr_c;
   logic [7:0]  id_c, wd_c;

   // ---------------- instance D: 3x3 ----------------
   logic        go_d, rdy_d, busy_d, done_d, ms_d, mv_d, ov_d;
   logic [1:0]  ia_d;
   logic [3:0]  wa_d;
   logic [1:0]  oi_d;
   logic [31:0] od_d, mr_d;
   logic [7:0]  id_d, wd_d;

   logic [7:0] rom_in_ab [0:3];
   logic [7:0] rom_w_ab  [0:7];
   logic [7:0] rom_in_c  [0:1];
   logic [7:0] rom_w_c   [0:1];
   logic [7:0] rom_in_d  [0:3];
   logic [7:0] rom_w_d   [0:15];

   // Behavioural 1-cycle-latency ROMs
   always @(posedge clk) begin
      id_a <= rom_in_ab[ia_a];  wd_a <= rom_w_ab[wa_a];
      id_b <= rom_in_ab[ia_b];  wd_b <= rom_w_ab[wa_b];
      id_c <= rom_in_c[ia_c];   wd_c <= rom_w_c[wa_c];
      id_d <= rom_in_d[ia_d];   wd_d <= rom_w_d[wa_d];
   end

   mlp_layer_seq #(.N_IN(4), .N_OUT(2), .ACC_WIDTH(32), .RELU(0)) dut_a (
      .clk(clk), .rst(rst), .go(go_a), .busy(busy_a), .done(done_a),
      .in_addr(ia_a), .w_addr(wa_a), .mac_start(ms_a), .mac_valid(mv_a),
      .mac_result(mr_a), .out_valid(ov_a), .out_ready(rdy_a),
      .out_idx(oi_a), .out_data(od_a));
   MLP_mac #(.DW(8), .ACC_WIDTH(32)) mac_a (
      .clk(clk), .rst(rst), .start(ms_a), .valid(mv_a), .a(id_a), .b(wd_a), .result(mr_a));

   mlp_layer_seq #(.N_IN(4), .N_OUT(2), .ACC_WIDTH(32), .RELU(1)) dut_b (
      .clk(clk), .rst(rst), .go(go_b), .busy(busy_b), .done(done_b),
      .in_addr(ia_b), .w_addr(wa_b), .mac_start(ms_b), .mac_valid(mv_b),
      .mac_result(mr_b), .out_valid(ov_b), .out_ready(rdy_b),
      .out_idx(oi_b), .out_data(od_b));
   MLP_mac #(.DW(8), .ACC_WIDTH(32)) mac_b (
      .clk(clk), .rst(rst), .start(ms_b), .valid(mv_b), .a(id_b), .b(wd_b), .result(mr_b));

   mlp_layer_seq #(.N_IN(1), .N_OUT(1), .ACC_WIDTH(32), .RELU(0)) dut_c (
      .clk(clk), .rst(rst), .go(go_c), .busy(busy_c), .done(done_c),
      .in_addr(ia_c), .w_addr(wa_c), .mac_start(ms_c), .mac_valid(mv_c),
      .mac_result(mr_c), .out_valid(ov_c), .out_ready(rdy_c),
      .out_idx(oi_c), .out_data(od_c));
   MLP_mac #(.DW(8), .ACC_WIDTH(32)) mac_c (
      .clk(clk), .rst(rst), .start(ms_c), .valid(mv_c), .a(id_c), .b(wd_c), .result(mr_c));

   mlp_layer_seq #(.N_IN(3), .N_OUT(3), .ACC_WIDTH(32), .RELU(0)) dut_d (
      .clk(clk), .rst(rst), .go(go_d), .busy(busy_d), .done(done_d),
      .in_addr(ia_d), .w_addr(wa_d), .mac_start(ms_d), .mac_valid(mv_d),
      .mac_result(mr_d), .out_valid(ov_d), .out_ready(rdy_d),
      .out_idx(oi_d), .out_data(od_d));
   MLP_mac #(.DW(8), .ACC_WIDTH(32)) mac_d (
      .clk(clk), .rst(rst), .start(ms_d), .valid(mv_d), .a(id_d), .b(wd_d), .result(mr_d));

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({busy_a, done_a, ms_a, mv_a, ov_a} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl_a: got %b, want 00000", {busy_a, done_a, ms_a, mv_a, ov_a});
      end
      tests_run++;
      if ({ia_a, wa_a, oi_a, od_a} !== 38'b0) begin
         tests_failed++;
         $display("FAIL reset_data_a: in_addr=%0d w_addr=%0d idx=%0d data=%0d, want all 0",
                  ia_a, wa_a, oi_a, od_a);
      end
      tests_run++;
      if ({busy_d, done_d, ms_d, mv_d, ov_d, ia_d, wa_d, oi_d, od_d} !== 45'b0) begin
         tests_failed++;
         $display("FAIL reset_d: busy=%b done=%b in_addr=%0d w_addr=%0d data=%0d, want all 0",
                  busy_d, done_d, ia_d, wa_d, od_d);
      end
      rst = 1'b0;
      tick();
   endtask

   // Basic layer, with optional stray go pulses that must be ignored.
   task automatic test_basic(input bit with_stray_go, input string tag);
      int ns0, nv0, ns1, nv1, both;
      logic exp_ov, exp_done, exp_busy;
      ns0 = 0; nv0 = 0; ns1 = 0; nv1 = 0; both = 0;
      rdy_a = 1'b1;
      go_a  = 1'b1;
      cyc   = 0;
      tick();
      go_a = 1'b0;
      while (cyc <= 16) begin
         go_a = with_stray_go && (cyc == 3 || cyc == 9 || cyc == 13);
         exp_ov   = (cyc == 6) || (cyc == 12);
         exp_done = (cyc == 13);
         exp_busy = (cyc >= 1) && (cyc <= 12);
         tests_run++;
         if ({ov_a, done_a, busy_a} !== {exp_ov, exp_done, exp_busy}) begin
            tests_failed++;
            $display("FAIL %s_ctrl cyc%0d: valid/done/busy=%b, want %b",
                     tag, cyc, {ov_a, done_a, busy_a}, {exp_ov, exp_done, exp_busy});
         end
         if (cyc == 6) begin
            tests_run++;
            if ({oi_a, od_a} !== {1'b0, 32'd3}) begin
               tests_failed++;
               $display("FAIL %s_out0: idx=%0d data=%0d, want idx=0 data=3", tag, oi_a, $signed(od_a));
            end
         end
         if (cyc == 12) begin
            tests_run++;
            if ({oi_a, od_a} !== {1'b1, 32'hFFFF_FFF7}) begin
               tests_failed++;
               $display("FAIL %s_out1: idx=%0d data=%0d, want idx=1 data=-9", tag, oi_a, $signed(od_a));
            end
         end
         if (ms_a && mv_a) both++;
         if (cyc <= 6) begin
            if (ms_a) ns0++;
            if (mv_a) nv0++;
         end else begin
            if (ms_a) ns1++;
            if (mv_a) nv1++;
         end
         tick();
      end
      go_a = 1'b0;
      tests_run++;
      if ({ns0, nv0, ns1, nv1, both} !== {32'd1, 32'd3, 32'd1, 32'd3, 32'd0}) begin
         tests_failed++;
         $display("FAIL %s_strobes: n0 start=%0d valid=%0d n1 start=%0d valid=%0d overlap=%0d, want 1/3/1/3/0",
                  tag, ns0, nv0, ns1, nv1, both);
      end
   endtask

   task automatic test_relu;
      rdy_b = 1'b1;
      go_b  = 1'b1;
      cyc   = 0;
      tick();
      go_b = 1'b0;
      while (cyc <= 14) begin
         tests_run++;
         if ({ov_b, done_b} !== {(cyc == 6 || cyc == 12), (cyc == 13)}) begin
            tests_failed++;
            $display("FAIL relu_ctrl cyc%0d: valid/done=%b%b", cyc, ov_b, done_b);
         end
         if (cyc == 6) begin
            tests_run++;
            if (od_b !== 32'd3) begin
               tests_failed++;
               $display("FAIL relu_out0: data=%0d, want 3", $signed(od_b));
            end
         end
         if (cyc == 12) begin
            tests_run++;
            if ({oi_b, od_b, mr_b} !== {1'b1, 32'd0, 32'hFFFF_FFF7}) begin
               tests_failed++;
               $display("FAIL relu_out1: idx=%0d data=%0d mac=%0d, want idx=1 data=0 mac=-9",
                        oi_b, $signed(od_b), $signed(mr_b));
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure;
      logic exp_ov;
      rdy_a = 1'b0;
      go_a  = 1'b1;
      cyc   = 0;
      tick();
      go_a = 1'b0;
      while (cyc <= 19) begin
         if (cyc == 11) rdy_a = 1'b1;
         exp_ov = (cyc >= 6 && cyc <= 11) || (cyc == 17);
         tests_run++;
         if ({ov_a, done_a} !== {exp_ov, (cyc == 18)}) begin
            tests_failed++;
            $display("FAIL bp_ctrl cyc%0d: valid/done=%b%b, want %b%b", cyc, ov_a, done_a, exp_ov, (cyc == 18));
         end
         if (cyc >= 6 && cyc <= 11) begin
            tests_run++;
            if ({oi_a, od_a, ia_a, wa_a} !== {1'b0, 32'd3, 2'd3, 3'd3}) begin
               tests_failed++;
               $display("FAIL bp_hold cyc%0d: idx=%0d data=%0d in_addr=%0d w_addr=%0d, want 0/3/3/3",
                        cyc, oi_a, $signed(od_a), ia_a, wa_a);
            end
         end
         if (cyc == 12) begin
            tests_run++;
            if ({busy_a, ia_a, wa_a} !== {1'b1, 2'd0, 3'd4}) begin
               tests_failed++;
               $display("FAIL bp_restart: busy=%b in_addr=%0d w_addr=%0d, want 1/0/4", busy_a, ia_a, wa_a);
            end
         end
         if (cyc == 13) begin
            tests_run++;
            if ({ms_a, mv_a} !== 2'b10) begin
               tests_failed++;
               $display("FAIL bp_start: start/valid=%b, want 10", {ms_a, mv_a});
            end
         end
         if (cyc == 17) begin
            tests_run++;
            if ({oi_a, od_a} !== {1'b1, 32'hFFFF_FFF7}) begin
               tests_failed++;
               $display("FAIL bp_out1: idx=%0d data=%0d, want 1/-9", oi_a, $signed(od_a));
            end
         end
         tick();
      end
      rdy_a = 1'b1;
   endtask

   task automatic test_edge_1x1;
      int nv;
      nv = 0;
      rdy_c = 1'b1;
      go_c  = 1'b1;
      cyc   = 0;
      tick();
      go_c = 1'b0;
      while (cyc <= 6) begin
         if (mv_c) nv++;
         tests_run++;
         if ({ms_c, ov_c, done_c, busy_c} !== {(cyc == 2), (cyc == 3), (cyc == 4), (cyc >= 1 && cyc <= 3)}) begin
            tests_failed++;
            $display("FAIL edge_ctrl cyc%0d: start/valid/done/busy=%b", cyc, {ms_c, ov_c, done_c, busy_c});
         end
         if (cyc == 3) begin
            tests_run++;
            if ({oi_c, od_c} !== {1'b0, 32'hFFFF_FFC1}) begin
               tests_failed++;
               $display("FAIL edge_out: idx=%0d data=%0d, want 0/-63", oi_c, $signed(od_c));
            end
         end
         tick();
      end
      tests_run++;
      if (nv !== 0) begin
         tests_failed++;
         $display("FAIL edge_no_valid: mac_valid count=%0d, want 0", nv);
      end
   endtask

   task automatic test_reset_mid;
      rdy_a = 1'b1;
      go_a  = 1'b1;
      cyc   = 0;
      tick();
      go_a = 1'b0;
      while (cyc <= 12) begin
         rst = (cyc == 8);
         if (cyc == 9) begin
            tests_run++;
            if ({busy_a, done_a, ms_a, mv_a, ov_a, ia_a, wa_a, oi_a, od_a} !== 43'b0) begin
               tests_failed++;
               $display("FAIL rst_mid: busy=%b start=%b valid=%b out_valid=%b in_addr=%0d w_addr=%0d data=%0d, want all 0",
                        busy_a, ms_a, mv_a, ov_a, ia_a, wa_a, od_a);
            end
         end
         if (cyc >= 10) begin
            tests_run++;
            if ({busy_a, ov_a, ms_a} !== 3'b0) begin
               tests_failed++;
               $display("FAIL rst_idle cyc%0d: busy/out_valid/start=%b, want 000", cyc, {busy_a, ov_a, ms_a});
            end
         end
         tick();
      end
      rst = 1'b0;
      test_basic(1'b0, "after_rst");
   endtask

   task automatic test_addr_3x3;
      int p, n;
      int exp_data [0:2];
      exp_data[0] = 14; exp_data[1] = 32; exp_data[2] = 50;
      rdy_d = 1'b1;
      go_d  = 1'b1;
      cyc   = 0;
      tick();
      go_d = 1'b0;
      while (cyc <= 17) begin
         p = (cyc - 1) % 5;
         n = (cyc - 1) / 5;
         if (cyc <= 15 && p < 3) begin
            tests_run++;
            if ({ia_d, wa_d} !== {p[1:0], 4'(n * 3 + p)}) begin
               tests_failed++;
               $display("FAIL addr cyc%0d: in_addr=%0d w_addr=%0d, want %0d/%0d", cyc, ia_d, wa_d, p, n * 3 + p);
            end
         end
         tests_run++;
         if ({ov_d, done_d} !== {(cyc <= 15 && p == 4), (cyc == 16)}) begin
            tests_failed++;
            $display("FAIL addr_ctrl cyc%0d: valid/done=%b%b", cyc, ov_d, done_d);
         end
         if (cyc <= 15 && p == 4) begin
            tests_run++;
            if ({oi_d, od_d} !== {n[1:0], exp_data[n]}) begin
               tests_failed++;
               $display("FAIL addr_out cyc%0d: idx=%0d data=%0d, want %0d/%0d", cyc, oi_d, $signed(od_d), n, exp_data[n]);
            end
         end
         tick();
      end
   endtask

   initial begin
      rom_in_ab = '{8'd3, 8'hFF, 8'd4, 8'd1};
      rom_w_ab  = '{8'd2, 8'd5, 8'hFE, 8'd10, 8'hFD, 8'd0, 8'd0, 8'd0};
      rom_in_c  = '{8'hF9, 8'd0};
      rom_w_c   = '{8'd9, 8'd0};
      rom_in_d  = '{8'd1, 8'd2, 8'd3, 8'd0};
      rom_w_d   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
                    8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      rst = 1'b1;
      go_a = 1'b0; go_b = 1'b0; go_c = 1'b0; go_d = 1'b0;
      rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1; rdy_d = 1'b1;
      cyc = 0;

      test_reset();
      test_basic(1'b0, "basic");
      test_relu();
      test_backpressure();
      test_edge_1x1();
      test_basic(1'b1, "go_ignored");
      test_reset_mid();
      test_addr_3x3();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
